nios_oci_trace_capture: RTL and testbench
=========================================

# nios_oci_trace_capture

Parametrised OCI debug-trace capture unit for the Nios base CPU simulation environment, successor to the passive trace test-bench stub. It samples the packed trace buffer (`dct_buffer`/`dct_count`), commits each full or flushed buffer as an entry into an internal FIFO, and exposes the entries on a valid/ready read port. It also sequences end-of-test flush and drain, and reports completion and overflow status.

## Interface
- `DCT_W`, 30: trace buffer width in bits.
- `CNT_W`, 4: trace count width.
- `FULL_COUNT`, 15: count value that marks a full buffer; must be below 2^CNT_W.
- `DEPTH`, 16: FIFO entries; power of 2, at least 2.
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `dct_buffer`  in  DCT_W  packed trace frames.
- `dct_count`  in  CNT_W  number of valid frames in `dct_buffer`.
- `test_ending`  in  1  level; its rising edge requests a flush.
- `test_has_ended`  in  1  level; the test is complete.
- `rd_data`  out  ENTRY_W  head entry, `{[ts,] count, buffer}`.
- `rd_valid`  out  1  head entry present.
- `rd_ready`  in  1  consumer accepts the head entry.
- `fifo_level`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; an entry was dropped.
- `drop_count`  out  16  dropped entries; saturates at 0xFFFF.
- `done`  out  1  drain complete.

## Operation
- Registered copies: `cnt_q` holds the previous `dct_count`; `end_q` holds the previous `test_ending`.
- Full capture: condition `dct_count==FULL_COUNT && cnt_q!=FULL_COUNT`. Only the transition captures, not the held level.
- State machine, states RUN, FLUSH, DRAIN, DONE. Reset state is RUN.
- RUN: full captures enabled. On `test_ending && !end_q`, go to FLUSH.
- FLUSH (exactly one cycle): if `dct_count!=0` and no full capture fires this cycle, push a partial entry `{dct_count, dct_buffer}`. Then go to DRAIN.
- Full capture and flush-edge in the same RUN cycle: push the full entry only. FLUSH then sees `dct_count==FULL_COUNT==cnt_q` and pushes nothing further.
- DRAIN: no captures. Go to DONE when `test_has_ended && fifo_level==0`.
- DONE: terminal until reset; `done=1`.
- Push and pop:
  - Pop occurs when `rd_valid && rd_ready`.
  - Push when full with no pop in the same cycle: entry dropped, `overflow` set, `drop_count` incremented.
  - Push when full with a pop in the same cycle: accepted, level unchanged.
- Reset mid-operation clears all state and FIFO contents immediately; entries in flight are lost.
- Reset values: `rd_valid=0`, `rd_data=0`, `fifo_level=0`, `overflow=0`, `drop_count=0`, `done=0`.

## Timing
- Capture latency: condition true before edge N, entry written at edge N, `rd_valid=1` in the cycle after edge N.
- `rd_data` is held stable while `rd_valid && !rd_ready`.
- Read is show-ahead: the next entry appears in the cycle after a pop.
- `fifo_level` updates at the same edge as the push or pop.
- `done` rises one cycle after the cycle in which the DRAIN exit condition holds.
- Back-to-back full captures need `dct_count` to leave FULL_COUNT for at least one cycle. Maximum capture rate is one entry per 2 cycles.

## Configuration
- `NIOS_OCI_TRACE_TIMESTAMP_EN` defined:
  - A 32-bit free-running cycle counter runs from reset and wraps 0xFFFFFFFF→0.
  - Its value at the push edge is prepended to each entry.
  - ENTRY_W = 32+CNT_W+DCT_W.
- Undefined: no counter; ENTRY_W = CNT_W+DCT_W.
- Everything else is identical in both builds.

## Structure
- Package `nios_oci_trace_pkg` holds:
  - the state enum (RUN, FLUSH, DRAIN, DONE);
  - `TS_W=32` and `DROP_W=16`;
  - the ENTRY_W helper function.
- Sub-module `nios_oci_trace_fifo`: synchronous show-ahead FIFO with parameters width and DEPTH, and outputs level and full/empty.
- Capture, FSM, counters and status live in the top module.

## Test plan
- Step `dct_count` 0→15 with `dct_buffer=30'h2AAAAAAA`, `rd_ready=1` -> one entry `{4'hF, 30'h2AAAAAAA}`, `rd_valid` high for exactly 1 cycle, one cycle after the capture edge.
- Hold `dct_count=15` for 10 cycles -> exactly one entry.
- Raise `test_ending` with `dct_count=5` -> partial entry with count 5. Then raise `test_has_ended` with FIFO empty -> `done=1` one cycle later.
- Raise `test_ending` in the same cycle `dct_count` goes 14→15 -> exactly one entry, count 15.
- Hold `rd_ready=0` and generate DEPTH+3 captures -> `fifo_level=DEPTH`, `overflow=1`, `drop_count=3`, first DEPTH entries intact and in order.
- Assert `reset_n=0` for 1 cycle with 4 entries queued -> all outputs at reset values, state RUN. With timestamp build: consecutive entries show correct cycle deltas.

Source files
------------

// File: rtl/nios_oci_trace_capture_pkg.sv
// -----------------------------------------------------------------------------
// nios_oci_trace_pkg
// Shared definitions for the OCI debug-trace capture unit:
//   - trace_state_t : capture sequencer states (RUN, FLUSH, DRAIN, DONE)
//   - TS_W / DROP_W : timestamp and drop-counter widths
//   - entry_w()     : width of one FIFO entry {[ts,] count, buffer}
// Optional feature macro: NIOS_OCI_TRACE_TIMESTAMP_EN (adds a 32-bit timestamp
// to each entry).
// -----------------------------------------------------------------------------
package nios_oci_trace_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_t;

    localparam int TS_W   = 32;
    localparam int DROP_W = 16;

    function automatic int entry_w(input int cnt_w, input int dct_w);
`ifdef NIOS_OCI_TRACE_TIMESTAMP_EN
        return TS_W + cnt_w + dct_w;
`else
        return cnt_w + dct_w;
`endif
    endfunction

endpackage

// File: rtl/nios_oci_trace_capture_if.sv
// -----------------------------------------------------------------------------
// nios_oci_trace_capture_if
// Valid/ready read port carrying captured trace entries.
//   rd_data  : head entry {[ts,] count, buffer}
//   rd_valid : head entry present
//   rd_ready : consumer accepts the head entry
// Modports: master = entry producer (capture unit), slave = consumer.
// -----------------------------------------------------------------------------
interface nios_oci_trace_capture_if #(
    parameter int ENTRY_W = 34
);
    logic [ENTRY_W-1:0] rd_data;
    logic               rd_valid;
    logic               rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/nios_oci_trace_capture_fifo.sv
// -----------------------------------------------------------------------------
// nios_oci_trace_fifo
// Synchronous show-ahead FIFO: the head entry is visible on rd_data whenever
// the FIFO is non-empty; rd_en consumes it.
//   clk, rst_n         : clock, asynchronous active-low reset
//   wr_en, wr_data     : write port (caller never writes when full without a read)
//   rd_en              : pop head (caller never pops when empty)
//   rd_data            : head entry, zero when empty
//   level, full, empty : occupancy status
// -----------------------------------------------------------------------------
module nios_oci_trace_fifo #(
    parameter  int WIDTH = 34,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (rd_en) rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage is data only; stale contents are masked by the empty check below.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wr_data;
    end

    assign level   = wptr_q - rptr_q;
    assign empty   = (wptr_q == rptr_q);
    assign full    = (level == (AW+1)'(DEPTH));
    assign rd_data = empty ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/nios_oci_trace_capture.sv
// -----------------------------------------------------------------------------
// nios_oci_trace_capture
// Samples the packed OCI trace buffer, commits each full (count transition to
// FULL_COUNT) or flushed partial buffer into a FIFO, and sequences end-of-test
// flush and drain.
//   clk, reset_n            : clock, asynchronous active-low reset
//   dct_buffer, dct_count   : packed trace frames and valid-frame count
//   test_ending             : rising edge requests a flush
//   test_has_ended          : test complete, allows DRAIN -> DONE
//   rd (master modport)     : valid/ready read port of entries
//   fifo_level              : FIFO occupancy
//   overflow, drop_count    : sticky drop flag, saturating drop counter
//   done                    : drain complete
// Optional feature macro: NIOS_OCI_TRACE_TIMESTAMP_EN prepends a free-running
// 32-bit cycle count (value at the push edge) to every entry.
// -----------------------------------------------------------------------------
module nios_oci_trace_capture
    import nios_oci_trace_pkg::*;
#(
    parameter  int DCT_W      = 30,
    parameter  int CNT_W      = 4,
    parameter  int FULL_COUNT = 15,
    parameter  int DEPTH      = 16,
    localparam int ENTRY_W    = entry_w(CNT_W, DCT_W),
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DCT_W-1:0]     dct_buffer,
    input  logic [CNT_W-1:0]     dct_count,
    input  logic                 test_ending,
    input  logic                 test_has_ended,
    nios_oci_trace_capture_if.master rd,
    output logic [LVL_W-1:0]     fifo_level,
    output logic                 overflow,
    output logic [DROP_W-1:0]    drop_count,
    output logic                 done
);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FULL_COUNT);

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [CNT_W-1:0]   cnt_q;
    logic               end_q;
    trace_state_t       state_q, state_d;
    logic               overflow_q;
    logic [DROP_W-1:0]  drop_cnt_q;
    logic               full_hit, held_full;
    logic               push, pop, fifo_wr, fifo_full, fifo_empty, drop;
    logic [ENTRY_W-1:0] push_data;

    assign full_hit  = (dct_count == FULL_CNT) && (cnt_q != FULL_CNT);
    assign held_full = (dct_count == FULL_CNT) && (cnt_q == FULL_CNT);

`ifdef NIOS_OCI_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ts_q <= '0;
        else          ts_q <= ts_q + 1'b1;
    end

    assign push_data = {ts_q, dct_count, dct_buffer};
`else
    assign push_data = {dct_count, dct_buffer};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            end_q      <= 1'b0;
            state_q    <= ST_RUN;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            cnt_q   <= dct_count;
            end_q   <= test_ending;
            state_q <= state_d;
            if (drop) begin
                overflow_q <= 1'b1;
                drop_cnt_q <= sat_inc(drop_cnt_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            ST_RUN: begin
                push = full_hit;
                if (test_ending && !end_q) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                // A buffer still sitting at FULL_COUNT was already committed
                // by the full capture; anything else non-empty is flushed.
                push    = (dct_count != '0) && !held_full;
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (test_has_ended && fifo_level == '0) state_d = ST_DONE;
            end
            ST_DONE: ;
            default: state_d = ST_RUN;
        endcase
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign pop     = rd.rd_valid && rd.rd_ready;
    assign fifo_wr = push && (!fifo_full || pop);
    assign drop    = push && fifo_full && !pop;

    nios_oci_trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .wr_en   (fifo_wr),
        .wr_data (push_data),
        .rd_en   (pop),
        .rd_data (rd.rd_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rd.rd_valid = !fifo_empty;
    assign overflow    = overflow_q;
    assign drop_count  = drop_cnt_q;
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_nios_oci_trace_capture.sv
// -----------------------------------------------------------------------------
// tb_nios_oci_trace_capture
// Directed bench for nios_oci_trace_capture (default parameters). Inputs are
// driven and outputs sampled 1 time unit after each rising clock edge.
// Entry checks compare the {count, buffer} field; the timestamp field is
// checked separately when NIOS_OCI_TRACE_TIMESTAMP_EN is defined.
// -----------------------------------------------------------------------------
module tb_nios_oci_trace_capture;
    import nios_oci_trace_pkg::*;

    localparam int DCT_W = 30;
    localparam int CNT_W = 4;
    localparam int DEPTH = 16;
    localparam int EW    = entry_w(CNT_W, DCT_W);

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [DCT_W-1:0] dct_buffer = '0;
    logic [CNT_W-1:0] dct_count = '0;
    logic             test_ending = 1'b0;
    logic             test_has_ended = 1'b0;
    logic [4:0]       fifo_level;
    logic             overflow;
    logic [15:0]      drop_count;
    logic             done;

    int n_checks = 0;
    int n_pass   = 0;

    nios_oci_trace_capture_if #(.ENTRY_W(EW)) rd_if ();

    nios_oci_trace_capture dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .rd             (rd_if),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        dct_buffer     = '0;
        dct_count      = '0;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        rd_if.rd_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    function automatic logic [63:0] ent(input logic [3:0] c, input logic [29:0] b);
        logic [33:0] e;
        e = {c, b};
        return 64'(e);
    endfunction

    function automatic logic [63:0] low(input logic [EW-1:0] d);
        logic [33:0] e;
        e = d[33:0];
        return 64'(e);
    endfunction

    int valid_cycles;
`ifdef NIOS_OCI_TRACE_TIMESTAMP_EN
    logic [31:0] ts_prev;
`endif

    initial begin
        rd_if.rd_ready = 1'b0;
        do_reset();

        // ---- reset values ----
        check("rst_valid",    rd_if.rd_valid, 0);
        check("rst_data",     low(rd_if.rd_data), 0);
        check("rst_level",    fifo_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop",     drop_count, 0);
        check("rst_done",     done, 0);

        // ---- full capture 0 -> 15, then held at 15 ----
        rd_if.rd_ready = 1'b1;
        dct_buffer     = 30'h2AAAAAAA;
        dct_count      = 4'hF;
        check("cap_pre_valid", rd_if.rd_valid, 0);
        tick();
        check("cap_valid", rd_if.rd_valid, 1);
        check("cap_data",  low(rd_if.rd_data), ent(4'hF, 30'h2AAAAAAA));
        check("cap_level", fifo_level, 1);
        valid_cycles = 0;
        repeat (10) begin
            tick();
            if (rd_if.rd_valid) valid_cycles++;
        end
        check("hold_no_recapture", valid_cycles, 0);

        // ---- flush edge coincident with 14 -> 15 ----
        do_reset();
        dct_buffer = 30'h3;
        dct_count  = 4'd14;
        tick();
        dct_count   = 4'hF;
        test_ending = 1'b1;
        tick();
        check("coinc_level1", fifo_level, 1);
        tick();
        tick();
        check("coinc_level_after_flush", fifo_level, 1);
        check("coinc_data", low(rd_if.rd_data), ent(4'hF, 30'h3));
        rd_if.rd_ready = 1'b1;
        tick();
        check("coinc_popped_valid", rd_if.rd_valid, 0);

        // ---- partial flush, drain, done ----
        do_reset();
        dct_buffer = 30'h1234;
        dct_count  = 4'd5;
        tick();
        test_ending = 1'b1;
        tick();
        check("flush_pre_valid", rd_if.rd_valid, 0);
        tick();
        check("flush_valid", rd_if.rd_valid, 1);
        check("flush_data",  low(rd_if.rd_data), ent(4'd5, 30'h1234));
        test_has_ended = 1'b1;
        tick();
        check("drain_held_data", low(rd_if.rd_data), ent(4'd5, 30'h1234));
        check("drain_not_done", done, 0);
        rd_if.rd_ready = 1'b1;
        tick();
        check("drain_level0", fifo_level, 0);
        check("drain_done_late", done, 0);
        tick();
        check("done_set", done, 1);

        // ---- overflow: DEPTH+3 captures with no reads ----
        do_reset();
        for (int i = 0; i < DEPTH + 3; i++) begin
            dct_buffer = 30'(i + 16);
            dct_count  = 4'hF;
            tick();
            dct_count  = 4'd0;
            tick();
        end
        check("ovf_level",    fifo_level, DEPTH);
        check("ovf_flag",     overflow, 1);
        check("ovf_drop_cnt", drop_count, 3);
        rd_if.rd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("ovf_entry%0d", i), low(rd_if.rd_data), ent(4'hF, 30'(i + 16)));
            tick();
        end
        check("ovf_empty_after", rd_if.rd_valid, 0);

        // ---- reset with entries queued ----
        rd_if.rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dct_buffer = 30'(i + 100);
            dct_count  = 4'hF;
            tick();
            dct_count  = 4'd0;
            tick();
        end
        check("midrst_level4", fifo_level, 4);
        reset_n = 1'b0;
        #1;
        check("midrst_async_level", fifo_level, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("midrst_valid",    rd_if.rd_valid, 0);
        check("midrst_data",     low(rd_if.rd_data), 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_drop",     drop_count, 0);
        check("midrst_done",     done, 0);
        check("midrst_state",    dut.state_q, ST_RUN);

`ifdef NIOS_OCI_TRACE_TIMESTAMP_EN
        // ---- timestamp deltas: captures 2 cycles apart ----
        for (int i = 0; i < 3; i++) begin
            dct_buffer = 30'(i);
            dct_count  = 4'hF;
            tick();
            dct_count  = 4'd0;
            tick();
        end
        rd_if.rd_ready = 1'b1;
        ts_prev = rd_if.rd_data[EW-1 -: 32];
        tick();
        for (int i = 1; i < 3; i++) begin
            check($sformatf("ts_delta%0d", i), 64'(rd_if.rd_data[EW-1 -: 32] - ts_prev), 2);
            ts_prev = rd_if.rd_data[EW-1 -: 32];
            tick();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
